uart_tx_sched: RTL and testbench

Transmit-side scheduler that shares one `uart_tx_top` transmitter among `NREQ` byte-stream requesters. It arbitrates round-robin at packet granularity and buffers granted bytes in a `DEPTH`-entry FIFO. It presents the FIFO head to the transmitter as `din`/`thre`. It retires entries on the transmitter's `pop` handshake.

---
 rtl/uart_tx_sched.sv | 214 +++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// ----------------------------------------------------------------------------
// uart_tx_sched
//
// Shares one UART transmitter among NREQ byte-stream requesters. Requesters
// are granted round-robin, one whole packet at a time. Granted bytes go into
// a DEPTH-entry FIFO whose head is presented to the transmitter as
// tx_din / tx_thre. One entry is retired on each rising edge of the
// transmitter's level-type pop signal.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   req_valid[i]    requester i offers a byte
//   req_data        byte of requester i at [8i+7:8i]
//   req_last[i]     offered byte ends the packet
//   req_ready[i]    byte of requester i accepted this cycle
//   tx_pop          transmitter pop (level, may stay high many cycles)
//   tx_sreg_empty   transmitter shift register empty
//   tx_din          FIFO head byte (8'h00 while empty)
//   tx_thre         1 = FIFO empty
//   grant_id        current / last granted requester
//   busy            high while a packet is being transferred
//   fifo_count      FIFO occupancy
//   timeout_err     one-cycle pulse when a stalled grant is revoked
//
// Optional feature (macro UART_TX_SCHED_BREAK_EN):
//   brk_req         pulse requesting a line break
//   tx_set_break    to transmitter set_break, high for BREAK_CYCLES cycles
// ----------------------------------------------------------------------------
module uart_tx_sched #(
    parameter int NREQ    = 4,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 255
`ifdef UART_TX_SCHED_BREAK_EN
    ,
    parameter int BREAK_CYCLES = 4096
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [8*NREQ-1:0]          req_data,
    input  logic [NREQ-1:0]            req_last,
    output logic [NREQ-1:0]            req_ready,
    input  logic                       tx_pop,
    input  logic                       tx_sreg_empty,
    output logic [7:0]                 tx_din,
    output logic                       tx_thre,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_count,
`ifdef UART_TX_SCHED_BREAK_EN
    input  logic                       brk_req,
    output logic                       tx_set_break,
`endif
    output logic                       timeout_err
);

    localparam int IDW = $clog2(NREQ);
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int IW  = 16;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t            r_state, w_next_state;
    logic [IDW-1:0]    r_ptr;
    logic [IDW-1:0]    r_grant;
    logic [IW-1:0]     r_idle;
    logic              r_timeout_err;
    logic              r_pop_q;
    logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [7:0]        r_mem [DEPTH];

    logic [NREQ-1:0]   w_ready;
    logic [IDW-1:0]    w_sel, w_cand;
    logic              w_any, w_load_grant, w_accept, w_timeout;
    logic              w_full, w_empty, w_retire, w_brk_block;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    // Only the rising edge of pop retires an entry; a rise on empty is dropped.
    assign w_retire = tx_pop && !r_pop_q && !w_empty;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_ready      = '0;
        w_sel        = '0;
        w_cand       = '0;
        w_any        = 1'b0;
        w_load_grant = 1'b0;
        w_accept     = 1'b0;
        w_timeout    = 1'b0;

        // Scan from the farthest candidate down to ptr+1 so the nearest
        // requester after the last grant is the one that sticks.
        for (int k = NREQ; k >= 1; k--) begin
            w_cand = IDW'((int'(r_ptr) + k) % NREQ);
            if (req_valid[w_cand]) begin
                w_sel = w_cand;
                w_any = 1'b1;
            end
        end

        unique case (r_state)
            ST_ARB: begin
                if (w_any && !w_brk_block) begin
                    w_load_grant = 1'b1;
                    w_next_state = ST_XFER;
                end
            end
            ST_XFER: begin
                w_ready[r_grant] = !w_full;
                w_accept         = req_valid[r_grant] && !w_full;
                if (w_accept) begin
                    if (req_last[r_grant]) w_next_state = ST_ARB;
                end else if (!req_valid[r_grant] &&
                             (r_idle == IW'(TIMEOUT - 1))) begin
                    w_timeout    = 1'b1;
                    w_next_state = ST_ARB;
                end
            end
            default: w_next_state = ST_ARB;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_ARB;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr         <= IDW'(NREQ - 1);
            r_grant       <= '0;
            r_idle        <= '0;
            r_timeout_err <= 1'b0;
            r_pop_q       <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            r_pop_q       <= tx_pop;
            r_timeout_err <= w_timeout;
            if (w_load_grant) r_grant <= w_sel;
            if ((w_accept && req_last[r_grant]) || w_timeout) r_ptr <= r_grant;
            // Idle time accumulates only while the granted requester is silent.
            if (r_state == ST_XFER && !req_valid[r_grant] && !w_timeout)
                r_idle <= r_idle + 1'b1;
            else
                r_idle <= '0;
            if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_retire) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; stale contents are unreachable
    // because the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_wr_ptr[AW-1:0]] <= req_data[{r_grant, 3'b000} +: 8];
    end

`ifdef UART_TX_SCHED_BREAK_EN
    localparam int BW = $clog2(BREAK_CYCLES + 1);
    logic          r_brk_pend, r_brk_active;
    logic [BW-1:0] r_brk_cnt;
    logic          w_brk_start;

    // A break starts only between packets with nothing left to shift out.
    assign w_brk_start = r_brk_pend && !r_brk_active && (r_state == ST_ARB) &&
                         w_empty && tx_sreg_empty;
    assign w_brk_block = r_brk_active || w_brk_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_brk_pend   <= 1'b0;
            r_brk_active <= 1'b0;
            r_brk_cnt    <= '0;
        end else begin
            if (brk_req)          r_brk_pend <= 1'b1;
            else if (w_brk_start) r_brk_pend <= 1'b0;
            if (w_brk_start) begin
                r_brk_active <= 1'b1;
                r_brk_cnt    <= '0;
            end else if (r_brk_active) begin
                if (r_brk_cnt == BW'(BREAK_CYCLES - 1)) r_brk_active <= 1'b0;
                r_brk_cnt <= r_brk_cnt + 1'b1;
            end
        end
    end

    assign tx_set_break = r_brk_active;
`else
    logic w_unused_sreg_empty;
    assign w_brk_block         = 1'b0;
    assign w_unused_sreg_empty = tx_sreg_empty;
`endif

    assign req_ready   = w_ready;
    assign tx_din      = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
    assign tx_thre     = w_empty;
    assign grant_id    = r_grant;
    assign busy        = (r_state == ST_XFER);
    assign fifo_count  = r_wr_ptr - r_rd_ptr;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_sched.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_sched
//
// Directed bench for uart_tx_sched (NREQ=4, DEPTH=4, TIMEOUT=10). A
// table of per-cycle vectors covers round-robin arbitration and the
// full/pop interaction; hand-written sequences cover the single packet,
// pop level handling, backpressure with simultaneous accept+pop, timeout
// and reset in the middle of a packet.
// ----------------------------------------------------------------------------
module tb_uart_tx_sched;

    localparam int NREQ    = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic        tx_pop = 1'b0;
    logic        tx_sreg_empty = 1'b1;
    logic [7:0]  tx_din;
    logic        tx_thre;
    logic [1:0]  grant_id;
    logic        busy;
    logic [2:0]  fifo_count;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_sched #(.NREQ(NREQ), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_pop        (tx_pop),
        .tx_sreg_empty (tx_sreg_empty),
        .tx_din        (tx_din),
        .tx_thre       (tx_thre),
        .grant_id      (grant_id),
        .busy          (busy),
        .fifo_count    (fifo_count),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid;
        logic       pop;
        logic [3:0] exp_ready;
        logic [1:0] exp_grant;
        logic       exp_busy;
        logic [2:0] exp_count;
        logic [7:0] exp_din;
    } rr_vec_t;

    rr_vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".ready"}, req_ready, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".count"}, fifo_count, 0);
        check({tag, ".thre"}, tx_thre, 1);
        check({tag, ".din"}, tx_din, 8'h00);
        check({tag, ".grant"}, grant_id, 0);
        check({tag, ".tmo"}, timeout_err, 0);
    endtask

    // Asserts reset away from the clock edge and releases it one edge later.
    task automatic do_reset(input string tag);
        req_valid = '0;
        req_last  = '0;
        tx_pop    = 1'b0;
        rst       = 1'b1;
        #1;
        check_reset_vals(tag);
        step();
        rst = 1'b0;
    endtask

    // Offers one byte from requester id and waits (bounded) for acceptance.
    task automatic push_byte(input int id, input logic [7:0] d, input logic last);
        logic ok;
        ok = 1'b0;
        req_valid[id]       = 1'b1;
        req_data[8*id +: 8] = d;
        req_last[id]        = last;
        for (int n = 0; n < 16 && !ok; n++) begin
            if (req_ready[id]) ok = 1'b1;
            step();
        end
        req_valid[id] = 1'b0;
        req_last[id]  = 1'b0;
        check("push_accept", ok, 1);
    endtask

    task automatic pop_pulse(input int hold);
        tx_pop = 1'b1;
        repeat (hold) step();
        tx_pop = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pkt [3];
        int k;
        logic w;

        // ---------------- reset state ----------------
        #2;
        check_reset_vals("reset0");
        step();
        rst = 1'b0;

        // ---------------- round-robin table ----------------
        // All four requesters hold 1-byte packets; bytes 11/22/33/44.
        vecs[0]  = '{4'hF, 1'b0, 4'h1, 2'd0, 1'b1, 3'd0, 8'h00};
        vecs[1]  = '{4'hF, 1'b0, 4'h0, 2'd0, 1'b0, 3'd1, 8'h11};
        vecs[2]  = '{4'hF, 1'b0, 4'h2, 2'd1, 1'b1, 3'd1, 8'h11};
        vecs[3]  = '{4'hF, 1'b0, 4'h0, 2'd1, 1'b0, 3'd2, 8'h11};
        vecs[4]  = '{4'hF, 1'b0, 4'h4, 2'd2, 1'b1, 3'd2, 8'h11};
        vecs[5]  = '{4'hF, 1'b0, 4'h0, 2'd2, 1'b0, 3'd3, 8'h11};
        vecs[6]  = '{4'hF, 1'b0, 4'h8, 2'd3, 1'b1, 3'd3, 8'h11};
        vecs[7]  = '{4'hF, 1'b0, 4'h0, 2'd3, 1'b0, 3'd4, 8'h11};
        vecs[8]  = '{4'hF, 1'b0, 4'h0, 2'd0, 1'b1, 3'd4, 8'h11};
        vecs[9]  = '{4'hF, 1'b1, 4'h1, 2'd0, 1'b1, 3'd3, 8'h22};
        vecs[10] = '{4'hF, 1'b1, 4'h0, 2'd0, 1'b0, 3'd4, 8'h22};
        vecs[11] = '{4'hF, 1'b0, 4'h0, 2'd1, 1'b1, 3'd4, 8'h22};
        vecs[12] = '{4'hF, 1'b1, 4'h2, 2'd1, 1'b1, 3'd3, 8'h33};
        req_data = 32'h44332211;
        req_last = 4'hF;
        for (int i = 0; i < 13; i++) begin
            req_valid = vecs[i].valid;
            tx_pop    = vecs[i].pop;
            step();
            check($sformatf("rr[%0d].ready", i), req_ready, vecs[i].exp_ready);
            check($sformatf("rr[%0d].grant", i), grant_id, vecs[i].exp_grant);
            check($sformatf("rr[%0d].busy", i), busy, vecs[i].exp_busy);
            check($sformatf("rr[%0d].count", i), fifo_count, vecs[i].exp_count);
            check($sformatf("rr[%0d].thre", i), tx_thre, (vecs[i].exp_count == 0));
            check($sformatf("rr[%0d].din", i), tx_din, vecs[i].exp_din);
        end

        // ---------------- single packet from requester 2 ----------------
        do_reset("reset1");
        pkt[0] = 8'hA5; pkt[1] = 8'h3C; pkt[2] = 8'h81;
        push_byte(2, pkt[0], 1'b0);
        check("pkt.grant", grant_id, 2);
        check("pkt.busy_mid", busy, 1);
        push_byte(2, pkt[1], 1'b0);
        push_byte(2, pkt[2], 1'b1);
        check("pkt.count", fifo_count, 3);
        check("pkt.busy_end", busy, 0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("pkt.din[%0d]", i), tx_din, pkt[i]);
            pop_pulse(3);
            check($sformatf("pkt.cnt[%0d]", i), fifo_count, 2 - i);
        end
        check("pkt.thre_done", tx_thre, 1);

        // ---------------- pop level / pop on empty ----------------
        push_byte(3, 8'h5A, 1'b0);
        check("lvl.grant", grant_id, 3);
        push_byte(3, 8'hC3, 1'b1);
        check("lvl.count2", fifo_count, 2);
        tx_pop = 1'b1;
        repeat (40) step();
        check("lvl.count_held", fifo_count, 1);
        check("lvl.din_held", tx_din, 8'hC3);
        tx_pop = 1'b0;
        step();
        pop_pulse(2);
        check("lvl.count0", fifo_count, 0);
        pop_pulse(2);
        check("empty_pop.count", fifo_count, 0);
        check("empty_pop.thre", tx_thre, 1);
        check("empty_pop.din", tx_din, 8'h00);

        // ---------------- full / backpressure ----------------
        do_reset("reset2");
        k = 0;
        req_valid[0]  = 1'b1;
        req_data[7:0] = 8'h10;
        for (int n = 0; n < 20 && k < 4; n++) begin
            w = req_ready[0];
            step();
            if (w) k++;
            req_data[7:0] = 8'h10 + 8'(k);
        end
        check("full.accepts", k, 4);
        check("full.count", fifo_count, 4);
        check("full.ready", req_ready, 0);
        repeat (3) step();
        check("full.count_hold", fifo_count, 4);
        check("full.ready_hold", req_ready, 0);
        tx_pop = 1'b1;
        step();
        check("full.pop_count", fifo_count, 3);
        check("full.pop_din", tx_din, 8'h11);
        check("full.pop_ready", req_ready, 1);
        req_valid[0] = 1'b0;
        tx_pop       = 1'b0;
        step();
        check("full.gap_count", fifo_count, 3);
        req_valid[0] = 1'b1;
        tx_pop       = 1'b1;
        step();
        check("simul.count", fifo_count, 3);
        check("simul.din", tx_din, 8'h12);
        req_data[7:0] = 8'h15;
        req_last[0]   = 1'b1;
        step();
        check("full.last_count", fifo_count, 4);
        check("full.last_busy", busy, 0);
        req_valid = '0;
        req_last  = '0;
        tx_pop    = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("full.drain[%0d]", i), tx_din, 8'h12 + 8'(i));
            pop_pulse(1);
        end
        check("full.drain_thre", tx_thre, 1);

        // ---------------- timeout ----------------
        do_reset("reset3");
        req_valid      = 4'b0010;
        req_data[15:8] = 8'h77;
        step();
        check("tmo.grant1", grant_id, 1);
        step();
        check("tmo.count1", fifo_count, 1);
        req_valid       = 4'b1000;
        req_data[31:24] = 8'h99;
        req_last[3]     = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i < 10) begin
                check($sformatf("tmo.quiet[%0d]", i), timeout_err, 0);
                check($sformatf("tmo.busy[%0d]", i), busy, 1);
            end else begin
                check("tmo.pulse", timeout_err, 1);
                check("tmo.busy_off", busy, 0);
            end
        end
        step();
        check("tmo.pulse_end", timeout_err, 0);
        check("tmo.grant3", grant_id, 3);
        check("tmo.busy3", busy, 1);
        step();
        req_valid = '0;
        req_last  = '0;
        check("tmo.count2", fifo_count, 2);
        check("tmo.din_kept", tx_din, 8'h77);
        pop_pulse(2);
        check("tmo.din_next", tx_din, 8'h99);
        pop_pulse(2);
        check("tmo.count0", fifo_count, 0);

        // ---------------- reset mid-XFER ----------------
        do_reset("reset4");
        push_byte(2, 8'h5E, 1'b1);
        for (int i = 0; i < 3; i++) push_byte(0, 8'hE0 + 8'(i), 1'b0);
        check("midrst.count", fifo_count, 4);
        check("midrst.busy", busy, 1);
        check("midrst.grant", grant_id, 0);
        req_valid[0] = 1'b1;
        do_reset("midrst");
        req_valid = 4'b1001;
        req_last  = 4'b1001;
        step();
        check("midrst.regrant", grant_id, 0);
        check("midrst.ready", req_ready, 4'b0001);
        check("midrst.count0", fifo_count, 0);
        req_valid = '0;
        req_last  = '0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
